pong_match_ctrl: RTL and testbench

Match sequencer for the pong game. It decides when the ball moves, when it is re-centred and which way it serves. It also keeps both players' scores and declares the winner. It sits between the player buttons and the ball/paddle engine, sampling per-frame miss events and gating ball motion. All logic runs on the pixel clock and advances on a one-cycle frame_tick strobe.

---
 rtl/pong_pkg.sv | 32 +++
 rtl/pong_btn_edge.sv | 20 ++
 rtl/pong_match_ctrl.sv | 147 ++++++++++++++
 tb/tb_pong_match_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: match states, winner codes and playfield constants.
package pong_pkg;

   // Match sequencer states; codes 5-7 are unused and recover to StIdle.
   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StServe    = 3'd1,
      StPlay     = 3'd2,
      StPoint    = 3'd3,
      StGameOver = 3'd4
   } match_state_e;

   localparam logic [1:0] WinNone = 2'b00;
   localparam logic [1:0] WinP1   = 2'b01;
   localparam logic [1:0] WinP2   = 2'b10;

   // Playfield geometry shared with the ball/paddle engine.
   localparam int unsigned ScreenW  = 640;
   localparam int unsigned ScreenH  = 480;
   localparam int unsigned PaddleH  = 48;
   localparam int unsigned BallSize = 8;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pong_btn_edge.sv
// Registers a synchronised button level and flags its rising edge.
module pong_btn_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   logic btn_q;

   // Previous-clock copy of the button level.
   always_ff @(posedge clk) begin
      if (!rst_n) btn_q <= 1'b0;
      else        btn_q <= btn;
   end

   // High for one clk when the button goes from released to pressed.
   assign pulse = btn & ~btn_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/point timing, scoring, pause and winner.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned POINT_FRAMES = 90,
   parameter int unsigned WIN_SCORE    = 7,
   parameter int unsigned SCORE_W      = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               btn_start,
   input  logic               btn_pause,
   input  logic               miss_left,
   input  logic               miss_right,
   output logic               ball_run,
   output logic               ball_reset,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [1:0]         winner,
   output logic [2:0]         game_state,
   output logic               paused
);

   localparam int unsigned CNT_W = cnt_width(max_u(SERVE_FRAMES, POINT_FRAMES));
   localparam logic [CNT_W-1:0]   ServeLoad = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [CNT_W-1:0]   PointLoad = CNT_W'(POINT_FRAMES - 1);
   localparam logic [SCORE_W-1:0] WinVal    = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] ScoreOne  = SCORE_W'(1);

   match_state_e     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             start_pulse;
   logic             pause_pulse;

   pong_btn_edge u_start_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_start),
      .pulse (start_pulse)
   );

   pong_btn_edge u_pause_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_pause),
      .pulse (pause_pulse)
   );

   assign game_state = state_q;

   // Match FSM; ball_run/ball_reset are registered alongside each state change.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         score1     <= '0;
         score2     <= '0;
         winner     <= WinNone;
         serve_dir  <= 1'b1;
         paused     <= 1'b0;
         ball_run   <= 1'b0;
         ball_reset <= 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               // A start edge loads the counter, so a same-clk frame_tick is not counted.
               if (start_pulse) begin
                  state_q <= StServe;
                  score1  <= '0;
                  score2  <= '0;
                  cnt_q   <= ServeLoad;
               end
            end
            StServe: begin
               if (frame_tick) begin
                  if (cnt_q == '0) begin
                     state_q    <= StPlay;
                     ball_reset <= 1'b0;
                     ball_run   <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            StPlay: begin
               if (frame_tick && !paused && (miss_left || miss_right)) begin
                  state_q  <= StPoint;
                  cnt_q    <= PointLoad;
                  paused   <= 1'b0;
                  ball_run <= 1'b0;
                  // Left miss has priority: only one point per frame.
                  if (miss_left) begin
                     if (score2 < WinVal) score2 <= score2 + ScoreOne;
                     serve_dir <= 1'b0;
                  end else begin
                     if (score1 < WinVal) score1 <= score1 + ScoreOne;
                     serve_dir <= 1'b1;
                  end
               end else if (pause_pulse) begin
                  paused   <= !paused;
                  ball_run <= paused;
               end
            end
            StPoint: begin
               if (frame_tick) begin
                  if (cnt_q == '0) begin
                     ball_reset <= 1'b1;
                     if (score1 == WinVal) begin
                        state_q <= StGameOver;
                        winner  <= WinP1;
                     end else if (score2 == WinVal) begin
                        state_q <= StGameOver;
                        winner  <= WinP2;
                     end else begin
                        state_q <= StServe;
                        cnt_q   <= ServeLoad;
                     end
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            StGameOver: begin
               if (start_pulse) begin
                  state_q   <= StServe;
                  score1    <= '0;
                  score2    <= '0;
                  winner    <= WinNone;
                  serve_dir <= 1'b1;
                  cnt_q     <= ServeLoad;
               end
            end
            default: begin
               state_q    <= StIdle;
               cnt_q      <= '0;
               paused     <= 1'b0;
               ball_run   <= 1'b0;
               ball_reset <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: stimulus queues expected outputs, monitor checks them.
module tb_pong_match_ctrl;

   localparam int unsigned SERVE_FRAMES = 3;
   localparam int unsigned POINT_FRAMES = 2;
   localparam int unsigned WIN_SCORE    = 7;
   localparam int unsigned SCORE_W      = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               frame_tick = 1'b0;
   logic               btn_start = 1'b0;
   logic               btn_pause = 1'b0;
   logic               miss_left = 1'b0;
   logic               miss_right = 1'b0;
   logic               ball_run;
   logic               ball_reset;
   logic               serve_dir;
   logic [SCORE_W-1:0] score1;
   logic [SCORE_W-1:0] score2;
   logic [1:0]         winner;
   logic [2:0]         game_state;
   logic               paused;

   pong_match_ctrl #(
      .SERVE_FRAMES (SERVE_FRAMES),
      .POINT_FRAMES (POINT_FRAMES),
      .WIN_SCORE    (WIN_SCORE),
      .SCORE_W      (SCORE_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .btn_start  (btn_start),
      .btn_pause  (btn_pause),
      .miss_left  (miss_left),
      .miss_right (miss_right),
      .ball_run   (ball_run),
      .ball_reset (ball_reset),
      .serve_dir  (serve_dir),
      .score1     (score1),
      .score2     (score2),
      .winner     (winner),
      .game_state (game_state),
      .paused     (paused)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic [3:0] s1;
      logic [3:0] s2;
      logic [1:0] win;
      logic       dir;
      logic       pau;
      logic       run;
      logic       rst;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one expectation per clk, compared just after the edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            x = q.pop_front();
            chk("game_state", 8'(game_state), 8'(x.st));
            chk("score1",     8'(score1),     8'(x.s1));
            chk("score2",     8'(score2),     8'(x.s2));
            chk("winner",     8'(winner),     8'(x.win));
            chk("serve_dir",  8'(serve_dir),  8'(x.dir));
            chk("paused",     8'(paused),     8'(x.pau));
            chk("ball_run",   8'(ball_run),   8'(x.run));
            chk("ball_reset", 8'(ball_reset), 8'(x.rst));
         end
      end
   end

   // Drive one clk of inputs; e holds the outputs required after that clk.
   task automatic step(input logic rn, input logic tk, input logic st, input logic pa,
                       input logic ml, input logic mr);
      @(negedge clk);
      rst_n      = rn;
      frame_tick = tk;
      btn_start  = st;
      btn_pause  = pa;
      miss_left  = ml;
      miss_right = mr;
      q.push_back(e);
   endtask

   task automatic reset_exp();
      e = '{st: 3'd0, s1: 4'd0, s2: 4'd0, win: 2'd0, dir: 1'b1, pau: 1'b0, run: 1'b0,
            rst: 1'b1};
   endtask

   task automatic press_start(input logic tk, input int hold);
      e.st = 3'd1; e.s1 = 4'd0; e.s2 = 4'd0; e.win = 2'd0; e.dir = 1'b1;
      e.run = 1'b0; e.rst = 1'b1;
      step(1, tk, 1, 0, 0, 0);
      repeat (hold) step(1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
   endtask

   // Three frame_ticks in SERVE, with idle clks between; PLAY after the third.
   task automatic serve_phase();
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 0, 0);
         if (i == 2) begin
            e.st = 3'd2; e.run = 1'b1; e.rst = 1'b0;
         end
         step(1, 1, 0, 0, 0, 0);
      end
   endtask

   task automatic point(input logic ml, input logic mr);
      if (ml) begin
         e.s2 = e.s2 + 4'd1; e.dir = 1'b0;
      end else begin
         e.s1 = e.s1 + 4'd1; e.dir = 1'b1;
      end
      e.st = 3'd3; e.run = 1'b0; e.rst = 1'b0;
      step(1, 1, 0, 0, ml, mr);
   endtask

   // Two frame_ticks in POINT; hs holds btn_start high throughout.
   task automatic point_hold(input logic hs);
      step(1, 1, hs, 0, 0, 0);
      e.rst = 1'b1;
      if (e.s1 == 4'd7) begin
         e.st = 3'd4; e.win = 2'b01;
      end else if (e.s2 == 4'd7) begin
         e.st = 3'd4; e.win = 2'b10;
      end else begin
         e.st = 3'd1;
      end
      step(1, 1, hs, 0, 0, 0);
   endtask

   initial begin
      reset_exp();
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 1, 1);
      // IDLE ignores ticks, misses and pause
      step(1, 1, 0, 0, 1, 1);
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0);

      // start -> SERVE, pause ignored in SERVE, 3 ticks -> PLAY
      press_start(0, 0);
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      serve_phase();

      // miss without frame_tick is ignored
      step(1, 0, 0, 0, 0, 1);
      point(0, 1);
      point_hold(0);
      serve_phase();
      point(1, 0);
      point_hold(0);
      serve_phase();

      // simultaneous misses: left wins, one point only
      point(1, 1);
      point_hold(0);
      serve_phase();

      // start edge in PLAY ignored
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);

      // pause held for 10 clks toggles once; misses ignored while paused
      e.pau = 1'b1; e.run = 1'b0;
      step(1, 0, 0, 1, 0, 0);
      step(1, 1, 0, 1, 1, 0);
      repeat (8) step(1, 0, 0, 1, 0, 0);
      step(1, 1, 0, 0, 0, 1);
      e.pau = 1'b0; e.run = 1'b1;
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0);

      // player 1 runs to WIN_SCORE; start held across the final hold gives no edge
      while (e.s1 < 4'd7) begin
         point(0, 1);
         if (e.s1 < 4'd7) begin
            point_hold(0);
            serve_phase();
         end else begin
            point_hold(1);
         end
      end
      repeat (3) step(1, 1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 1, 0);
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0);

      // restart with a same-clk tick (not counted), start held 10 clks
      press_start(1, 9);
      serve_phase();

      // player 2 to 5, then reset while in POINT
      for (int i = 0; i < 5; i++) begin
         point(1, 0);
         if (i < 4) begin
            point_hold(0);
            serve_phase();
         end
      end
      reset_exp();
      step(0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
